// File: rtl/vend_pkg.sv
// Shared types and constants for the vending session arbiter.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SESSION = 2'd1,
    CLOSE   = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, scanning cyclically.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   win_sum;

  // rot[i] is the request of the kiosk i positions after rr_ptr
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      assign sum     = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign idx     = IDX_W'((sum >= N_W) ? sum - N_W : sum);
      assign rot[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offset = IDX_W'(i);
    end
  end

  assign win_sum = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner  = IDX_W'((win_sum >= N_W) ? win_sum - N_W : win_sum);
  assign valid   = |req;

endmodule

// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter sharing one vending_machine core between N_KIOSK kiosks.
// Optional VEND_ARB_STATS_EN adds saturating sale_cnt/abort_cnt outputs.
module vend_session_arbiter
  import vend_pkg::*;
#(
  parameter int N_KIOSK = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_KIOSK-1:0]     req,
  input  logic [2*N_KIOSK-1:0]   kiosk_coin,
  input  logic                   vm_p,
  input  logic                   vm_ch,
  output logic [1:0]             vm_coin,
  output logic                   vm_clr,
  output logic [N_KIOSK-1:0]     gnt,
  output logic [N_KIOSK-1:0]     done,
  output logic [N_KIOSK-1:0]     abort,
  output logic [N_KIOSK-1:0]     ch_out,
  output logic                   busy
`ifdef VEND_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]      sale_cnt,
  output logic [STAT_W-1:0]      abort_cnt
`endif
);

  localparam int IDX_W = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [N_KIOSK-1:0] GNT_ONE  = N_KIOSK'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_KIOSK - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_MAX  = '1;

  state_t               state_reg, state_next;
  logic [N_KIOSK-1:0]   gnt_reg, gnt_next;
  logic [N_KIOSK-1:0]   done_reg, done_next;
  logic [N_KIOSK-1:0]   abort_reg, abort_next;
  logic                 vm_clr_reg, vm_clr_next;
  logic [IDX_W-1:0]     winner_reg, winner_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;

  logic [1:0]           coin_arr [N_KIOSK];
  logic [1:0]           owner_coin;
  logic                 coin_hit;
  logic                 idle_expired;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_KIOSK; gi++) begin : g_coin
      assign coin_arr[gi] = kiosk_coin[2*gi +: 2];
    end
  endgenerate

  assign owner_coin   = coin_arr[winner_reg];
  assign coin_hit     = (owner_coin != COIN_NONE);
  assign idle_expired = !coin_hit && (timer_reg == TMR_LAST);

  rr_pick #(
    .N     (N_KIOSK),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    winner_next = winner_reg;
    rr_ptr_next = rr_ptr_reg;
    timer_next  = timer_reg;
    done_next   = '0;
    abort_next  = '0;
    vm_clr_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next    = GNT_ONE << pick_idx;
          winner_next = pick_idx;
          rr_ptr_next = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
          timer_next  = '0;
          state_next  = SESSION;
        end
      end
      SESSION: begin
        if (coin_hit)                 timer_next = '0;
        else if (timer_reg != TMR_MAX) timer_next = timer_reg + 1'b1;
        // A product pulse outranks a timeout or walk-away in the same cycle
        if (vm_p) begin
          done_next  = gnt_reg;
          state_next = CLOSE;
        end else if (idle_expired || !req[winner_reg]) begin
          abort_next  = gnt_reg;
          vm_clr_next = 1'b1;
          state_next  = CLOSE;
        end
      end
      CLOSE: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      done_reg   <= '0;
      abort_reg  <= '0;
      vm_clr_reg <= 1'b0;
      winner_reg <= '0;
      rr_ptr_reg <= '0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      abort_reg  <= abort_next;
      vm_clr_reg <= vm_clr_next;
      winner_reg <= winner_next;
      rr_ptr_reg <= rr_ptr_next;
      timer_reg  <= timer_next;
    end
  end

  assign vm_coin = (state_reg == SESSION) ? owner_coin : COIN_NONE;
  assign ch_out  = gnt_reg & {N_KIOSK{vm_ch}};
  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign abort   = abort_reg;
  assign vm_clr  = vm_clr_reg;
  assign busy    = (state_reg != IDLE);

`ifdef VEND_ARB_STATS_EN
  logic [STAT_W-1:0] sale_cnt_reg, abort_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sale_cnt_reg  <= '0;
      abort_cnt_reg <= '0;
    end else if (state_reg == CLOSE) begin
      if (|done_reg && sale_cnt_reg != STAT_MAX)   sale_cnt_reg  <= sale_cnt_reg + 1'b1;
      if (|abort_reg && abort_cnt_reg != STAT_MAX) abort_cnt_reg <= abort_cnt_reg + 1'b1;
    end
  end

  assign sale_cnt  = sale_cnt_reg;
  assign abort_cnt = abort_cnt_reg;
`endif

endmodule
